operand_fetch: RTL and testbench

OPERAND_FETCH -- requirements
Module: operand_fetch

---
 rtl/operand_fetch_pkg.sv | 23 ++
 rtl/operand_scoreboard.sv | 43 ++++
 rtl/operand_fetch.sv | 129 ++++++++++++
 tb/tb_operand_fetch.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_fetch_pkg.sv
// Shared CPU package: register file geometry used by operand fetch, the
// busy-bit scoreboard and the register file itself.
//   CPU_DATA_W   : operand/register width
//   CPU_ADDR_W   : register address width
//   CPU_NUM_REGS : architectural register count (r0 hardwired to zero)
package operand_fetch_pkg;

  localparam int CPU_DATA_W   = 36;
  localparam int CPU_ADDR_W   = 5;
  localparam int CPU_NUM_REGS = 32;

  typedef logic [CPU_ADDR_W-1:0] reg_addr_t;

  // One-hot register mask; r0 never appears so its busy bit stays clear.
  function automatic logic [CPU_NUM_REGS-1:0] reg_onehot(input logic en,
                                                         input reg_addr_t addr);
    logic [CPU_NUM_REGS-1:0] m;
    m = '0;
    if (en && (addr != '0)) m[addr] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/operand_scoreboard.sv
// Busy-bit scoreboard: one bit per architectural register, set when an
// instruction that writes the register issues, cleared on its writeback.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   set_en, set_addr         : mark a destination busy
//   clr_en, clr_addr         : writeback clears a register
//   q1_addr/q2_addr/qd_addr  : source 1, source 2, destination queries
//   q1_busy/q2_busy/qd_busy  : current busy state for each query
module operand_scoreboard
  import operand_fetch_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      set_en,
  input  reg_addr_t set_addr,
  input  logic      clr_en,
  input  reg_addr_t clr_addr,
  input  reg_addr_t q1_addr,
  input  reg_addr_t q2_addr,
  input  reg_addr_t qd_addr,
  output logic      q1_busy,
  output logic      q2_busy,
  output logic      qd_busy
);

  logic [CPU_NUM_REGS-1:0] busy;
  logic [CPU_NUM_REGS-1:0] set_mask;
  logic [CPU_NUM_REGS-1:0] clr_mask;

  assign set_mask = reg_onehot(set_en, set_addr);
  assign clr_mask = reg_onehot(clr_en, clr_addr);

  // Set is applied after clear so a same-cycle set/clear leaves the bit set.
  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= (busy & ~clr_mask) | set_mask;
  end

  assign q1_busy = busy[q1_addr];
  assign q2_busy = busy[q2_addr];
  assign qd_busy = busy[qd_addr];

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: reads the register file, checks the scoreboard for
// RAW/WAW hazards, forwards same-cycle writeback data, and presents a held
// operand bundle to execute with a valid/ready handshake (latency 1).
// Ports:
//   clk, rst                          : clock, synchronous active-high reset
//   dec_valid/dec_ready               : issue handshake from decode
//   dec_rs1/dec_rs2/dec_rd/dec_wen    : decoded register fields
//   rf_read1_addr/rf_read2_addr       : register file read addresses
//   rf_read1/rf_read2                 : read data, one cycle after address
//   rf_write_enable/addr/data         : register file write port
//   wb_valid/wb_addr/wb_data          : writeback from execute
//   ex_valid/ex_ready                 : handshake to execute
//   ex_op1/ex_op2/ex_rd/ex_wen        : operand bundle
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int ADDR_W = CPU_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dec_valid,
  output logic              dec_ready,
  input  logic [ADDR_W-1:0] dec_rs1,
  input  logic [ADDR_W-1:0] dec_rs2,
  input  logic [ADDR_W-1:0] dec_rd,
  input  logic              dec_wen,
  output logic [ADDR_W-1:0] rf_read1_addr,
  output logic [ADDR_W-1:0] rf_read2_addr,
  input  logic [DATA_W-1:0] rf_read1,
  input  logic [DATA_W-1:0] rf_read2,
  output logic              rf_write_enable,
  output logic [ADDR_W-1:0] rf_write_addr,
  output logic [DATA_W-1:0] rf_write_data,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [DATA_W-1:0] ex_op1,
  output logic [DATA_W-1:0] ex_op2,
  output logic [ADDR_W-1:0] ex_rd,
  output logic              ex_wen
);

  logic busy1, busy2, busyd;
  logic wb_hit1, wb_hit2;
  logic fwd1, fwd2;
  logic hazard, issue;

  // Capture/hold state. live*_q marks the first cycle after issue, when the
  // operand still comes straight from the register file read port; after
  // that cycle it is frozen in op*_q so later reads cannot disturb it.
  logic              valid_q;
  logic              live1_q, live2_q;
  logic [DATA_W-1:0] op1_q, op2_q;
  logic [ADDR_W-1:0] rd_q;
  logic              wen_q;

  assign rf_read1_addr   = dec_rs1;
  assign rf_read2_addr   = dec_rs2;
  assign rf_write_enable = wb_valid && (wb_addr != '0);
  assign rf_write_addr   = wb_addr;
  assign rf_write_data   = wb_data;

  operand_scoreboard u_sb (
    .clk      (clk),
    .rst      (rst),
    .set_en   (issue && dec_wen),
    .set_addr (dec_rd),
    .clr_en   (wb_valid),
    .clr_addr (wb_addr),
    .q1_addr  (dec_rs1),
    .q2_addr  (dec_rs2),
    .qd_addr  (dec_rd),
    .q1_busy  (busy1),
    .q2_busy  (busy2),
    .qd_busy  (busyd)
  );

  assign wb_hit1 = wb_valid && (wb_addr == dec_rs1);
  assign wb_hit2 = wb_valid && (wb_addr == dec_rs2);
  // r0 never forwards: its operand is always zero.
  assign fwd1    = wb_hit1 && (wb_addr != '0);
  assign fwd2    = wb_hit2 && (wb_addr != '0);

  // A busy source is fine when its result is arriving this very cycle.
  assign hazard  = (busy1 && !wb_hit1) || (busy2 && !wb_hit2) || (dec_wen && busyd);

  assign dec_ready = !rst && !hazard && (!valid_q || ex_ready);
  assign issue     = dec_valid && dec_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      live1_q <= 1'b0;
      live2_q <= 1'b0;
      op1_q   <= '0;
      op2_q   <= '0;
      rd_q    <= '0;
      wen_q   <= 1'b0;
    end else if (issue) begin
      valid_q <= 1'b1;
      live1_q <= !fwd1 && (dec_rs1 != '0);
      live2_q <= !fwd2 && (dec_rs2 != '0);
      op1_q   <= fwd1 ? wb_data : '0;
      op2_q   <= fwd2 ? wb_data : '0;
      rd_q    <= dec_rd;
      wen_q   <= dec_wen;
    end else begin
      if (ex_ready) valid_q <= 1'b0;
      if (live1_q) begin
        op1_q   <= rf_read1;
        live1_q <= 1'b0;
      end
      if (live2_q) begin
        op2_q   <= rf_read2;
        live2_q <= 1'b0;
      end
    end
  end

  assign ex_valid = valid_q;
  assign ex_op1   = live1_q ? rf_read1 : op1_q;
  assign ex_op2   = live2_q ? rf_read2 : op2_q;
  assign ex_rd    = rd_q;
  assign ex_wen   = wen_q;

endmodule

// File: tb/tb_operand_fetch.sv
module tb_operand_fetch;

  typedef struct packed {
    logic [35:0] op1;
    logic [35:0] op2;
    logic [4:0]  rd;
    logic        wen;
  } bnd_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        dec_valid, dec_ready, dec_wen;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic [4:0]  rf_read1_addr, rf_read2_addr, rf_write_addr;
  logic [35:0] rf_read1, rf_read2, rf_write_data;
  logic        rf_write_enable;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [35:0] wb_data;
  logic        ex_valid, ex_ready, ex_wen;
  logic [35:0] ex_op1, ex_op2;
  logic [4:0]  ex_rd;

  int n_cmp = 0;
  int n_err = 0;

  bnd_t exp_q[$];
  bnd_t act_q[$];
  bnd_t e, a;

  // Register file model driven by the DUT's write port; r0 holds garbage so
  // zero-source forcing is visible.
  logic [35:0] rf_mem   [32] = '{default: 36'h0_DEAD_BEEF};
  logic [35:0] exp_regs [32] = '{default: 36'h0_DEAD_BEEF};

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rf_read1 <= rf_mem[rf_read1_addr];
    rf_read2 <= rf_mem[rf_read2_addr];
    if (rf_write_enable) rf_mem[rf_write_addr] <= rf_write_data;
  end

  operand_fetch dut (
    .clk(clk), .rst(rst),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd), .dec_wen(dec_wen),
    .rf_read1_addr(rf_read1_addr), .rf_read2_addr(rf_read2_addr),
    .rf_read1(rf_read1), .rf_read2(rf_read2),
    .rf_write_enable(rf_write_enable), .rf_write_addr(rf_write_addr),
    .rf_write_data(rf_write_data),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_rd(ex_rd), .ex_wen(ex_wen)
  );

  // One clock: at negedge record issues (expected bundle from the model) and
  // handoffs (actual bundle); at posedge advance the model; return #1 later.
  task automatic tick();
    bnd_t x;
    @(negedge clk);
    if (dec_valid && dec_ready && !rst) begin
      x.op1 = (dec_rs1 == 0) ? 36'd0 :
              (wb_valid && wb_addr == dec_rs1) ? wb_data : exp_regs[dec_rs1];
      x.op2 = (dec_rs2 == 0) ? 36'd0 :
              (wb_valid && wb_addr == dec_rs2) ? wb_data : exp_regs[dec_rs2];
      x.rd  = dec_rd;
      x.wen = dec_wen;
      exp_q.push_back(x);
    end
    if (ex_valid && ex_ready) act_q.push_back({ex_op1, ex_op2, ex_rd, ex_wen});
    @(posedge clk);
    if (rst) exp_q.delete();
    if (wb_valid && wb_addr != 0) exp_regs[wb_addr] = wb_data;
    #1;
  endtask

  task automatic issue_set(input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd, input logic wen);
    dec_valid = 1'b1; dec_rs1 = rs1; dec_rs2 = rs2; dec_rd = rd; dec_wen = wen;
  endtask

  task automatic test_reset();
    tick(); tick();
    issue_set(0, 0, 0, 0);
    #1;
    n_cmp++;
    if (dec_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b required 0", dec_ready); end
    n_cmp++;
    if ({ex_valid, ex_op1, ex_op2, ex_rd, ex_wen} !== 79'd0) begin
      n_err++; $display("FAIL reset_state: got v=%b op1=%h op2=%h rd=%0d wen=%b required all 0",
                        ex_valid, ex_op1, ex_op2, ex_rd, ex_wen);
    end
    rst = 1'b0; ex_ready = 1'b1;
    #1;
    n_cmp++;
    if (dec_ready !== 1'b1) begin n_err++; $display("FAIL reset_first_issue: got %b required 1", dec_ready); end
    tick();
    dec_valid = 1'b0;
    tick();
    while (exp_q.size() != 0 || act_q.size() != 0) begin
      n_cmp++;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : bnd_t'('x);
      a = (act_q.size() != 0) ? act_q.pop_front() : bnd_t'('x);
      if (a !== e) begin n_err++; $display("FAIL reset_bundle: got %h required %h", a, e); end
    end
  endtask

  task automatic test_rf_write();
    for (int i = 1; i <= 12; i++) begin
      wb_valid = 1'b1; wb_addr = 5'(i);
      wb_data  = (i == 3) ? 36'h0_0000_00AA : (i == 4) ? 36'h0_0000_0055 :
                 36'h1_0000_0000 + 36'(i) * 36'h0_0101_0101;
      #1;
      n_cmp++;
      if ({rf_write_enable, rf_write_addr, rf_write_data} !== {1'b1, wb_addr, wb_data}) begin
        n_err++; $display("FAIL rf_write: got en=%b a=%0d d=%h required en=1 a=%0d d=%h",
                          rf_write_enable, rf_write_addr, rf_write_data, wb_addr, wb_data);
      end
      tick();
    end
    wb_addr = 5'd0; wb_data = 36'h5_5555_5555;
    #1;
    n_cmp++;
    if (rf_write_enable !== 1'b0) begin n_err++; $display("FAIL rf_write_r0: got en=%b required 0", rf_write_enable); end
    tick();
    wb_valid = 1'b0;
  endtask

  task automatic test_basic();
    ex_ready = 1'b1;
    issue_set(3, 4, 5, 1);
    #1;
    n_cmp++;
    if (dec_ready !== 1'b1) begin n_err++; $display("FAIL basic_ready: got %b required 1", dec_ready); end
    tick();
    dec_valid = 1'b0;
    n_cmp++;
    if ({ex_valid, ex_op1, ex_op2} !== {1'b1, 36'h0_0000_00AA, 36'h0_0000_0055}) begin
      n_err++; $display("FAIL basic_latency: got v=%b op1=%h op2=%h required v=1 op1=aa op2=55",
                        ex_valid, ex_op1, ex_op2);
    end
    tick();
    n_cmp++;
    if (ex_valid !== 1'b0) begin n_err++; $display("FAIL basic_drop: got ex_valid=%b required 0", ex_valid); end
    while (exp_q.size() != 0 || act_q.size() != 0) begin
      n_cmp++;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : bnd_t'('x);
      a = (act_q.size() != 0) ? act_q.pop_front() : bnd_t'('x);
      if (a !== e) begin n_err++; $display("FAIL basic_bundle: got %h required %h", a, e); end
    end
  endtask

  task automatic test_hazard();
    issue_set(5, 4, 6, 1);
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++;
      if (dec_ready !== 1'b0) begin n_err++; $display("FAIL hazard_stall: cycle %0d got %b required 0", k, dec_ready); end
      tick();
    end
    wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 36'h1_2345_6789;
    #1;
    n_cmp++;
    if (dec_ready !== 1'b1) begin n_err++; $display("FAIL hazard_release: got %b required 1", dec_ready); end
    tick();
    wb_valid = 1'b0; dec_valid = 1'b0;
    n_cmp++;
    if (ex_op1 !== 36'h1_2345_6789) begin n_err++; $display("FAIL hazard_fwd: got %h required 123456789", ex_op1); end
    tick();
    // retire r6 so later tests see a clean scoreboard
    wb_valid = 1'b1; wb_addr = 5'd6; wb_data = 36'h0_0000_6666;
    tick();
    wb_valid = 1'b0;
    while (exp_q.size() != 0 || act_q.size() != 0) begin
      n_cmp++;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : bnd_t'('x);
      a = (act_q.size() != 0) ? act_q.pop_front() : bnd_t'('x);
      if (a !== e) begin n_err++; $display("FAIL hazard_bundle: got %h required %h", a, e); end
    end
  endtask

  task automatic test_hold();
    ex_ready = 1'b0;
    issue_set(3, 4, 8, 0);
    tick();
    issue_set(1, 2, 0, 0);
    for (int k = 0; k < 4; k++) begin
      wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 36'h0_0000_0100 + 36'(k);
      #1;
      n_cmp++;
      if ({ex_valid, ex_op1, ex_op2, ex_rd, dec_ready} !==
          {1'b1, 36'h0_0000_00AA, 36'h0_0000_0055, 5'd8, 1'b0}) begin
        n_err++; $display("FAIL hold_stable: cycle %0d got v=%b op1=%h op2=%h rd=%0d rdy=%b required v=1 op1=aa op2=55 rd=8 rdy=0",
                          k, ex_valid, ex_op1, ex_op2, ex_rd, dec_ready);
      end
      tick();
    end
    wb_valid = 1'b0; dec_valid = 1'b0; ex_ready = 1'b1;
    tick();
    n_cmp++;
    if ({ex_valid, 32'(act_q.size())} !== {1'b0, 32'd1}) begin
      n_err++; $display("FAIL hold_handoff: got v=%b handoffs=%0d required v=0 handoffs=1", ex_valid, act_q.size());
    end
    while (exp_q.size() != 0 || act_q.size() != 0) begin
      n_cmp++;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : bnd_t'('x);
      a = (act_q.size() != 0) ? act_q.pop_front() : bnd_t'('x);
      if (a !== e) begin n_err++; $display("FAIL hold_bundle: got %h required %h", a, e); end
    end
  endtask

  task automatic test_zero();
    ex_ready = 1'b1;
    issue_set(0, 0, 0, 1);
    #1;
    n_cmp++;
    if (dec_ready !== 1'b1) begin n_err++; $display("FAIL zero_ready: got %b required 1", dec_ready); end
    tick();
    issue_set(3, 4, 10, 0);
    n_cmp++;
    if ({dec_ready, ex_op1, ex_op2} !== {1'b1, 72'd0}) begin
      n_err++; $display("FAIL zero_b2b: got rdy=%b op1=%h op2=%h required rdy=1 op1=0 op2=0", dec_ready, ex_op1, ex_op2);
    end
    tick();
    dec_valid = 1'b0;
    tick();
    while (exp_q.size() != 0 || act_q.size() != 0) begin
      n_cmp++;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : bnd_t'('x);
      a = (act_q.size() != 0) ? act_q.pop_front() : bnd_t'('x);
      if (a !== e) begin n_err++; $display("FAIL zero_bundle: got %h required %h", a, e); end
    end
  endtask

  task automatic test_same_cycle();
    ex_ready = 1'b1;
    wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 36'h0_0000_0777;
    issue_set(0, 0, 7, 1);
    #1;
    n_cmp++;
    if (dec_ready !== 1'b1) begin n_err++; $display("FAIL same_ready: got %b required 1", dec_ready); end
    tick();
    wb_valid = 1'b0;
    issue_set(7, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      #1;
      n_cmp++;
      if (dec_ready !== 1'b0) begin n_err++; $display("FAIL same_set_wins: cycle %0d got %b required 0", k, dec_ready); end
      tick();
    end
    wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 36'h9_8765_4321;
    tick();
    wb_valid = 1'b0; dec_valid = 1'b0;
    tick();
    while (exp_q.size() != 0 || act_q.size() != 0) begin
      n_cmp++;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : bnd_t'('x);
      a = (act_q.size() != 0) ? act_q.pop_front() : bnd_t'('x);
      if (a !== e) begin n_err++; $display("FAIL same_bundle: got %h required %h", a, e); end
    end
  endtask

  task automatic test_back_to_back();
    ex_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      issue_set(5'($urandom_range(0, 12)), 5'($urandom_range(0, 12)),
                5'($urandom_range(0, 31)), 1'b0);
      wb_valid = 1'($urandom_range(0, 1));
      wb_addr  = 5'($urandom_range(1, 12));
      wb_data  = {4'($urandom_range(0, 15)), 32'($urandom)};
      #1;
      n_cmp++;
      if (dec_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready: cycle %0d got %b required 1", k, dec_ready); end
      tick();
    end
    dec_valid = 1'b0; wb_valid = 1'b0;
    tick();
    while (exp_q.size() != 0 || act_q.size() != 0) begin
      n_cmp++;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : bnd_t'('x);
      a = (act_q.size() != 0) ? act_q.pop_front() : bnd_t'('x);
      if (a !== e) begin n_err++; $display("FAIL b2b_bundle: got %h required %h", a, e); end
    end
  endtask

  task automatic test_reset_mid();
    ex_ready = 1'b0;
    issue_set(1, 2, 9, 1);
    tick();
    dec_valid = 1'b0;
    n_cmp++;
    if (ex_valid !== 1'b1) begin n_err++; $display("FAIL rstmid_pre: got ex_valid=%b required 1", ex_valid); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({ex_valid, ex_op1, ex_op2, ex_rd, ex_wen} !== 79'd0) begin
      n_err++; $display("FAIL rstmid_flush: got v=%b op1=%h op2=%h rd=%0d wen=%b required all 0",
                        ex_valid, ex_op1, ex_op2, ex_rd, ex_wen);
    end
    issue_set(9, 9, 9, 1);
    ex_ready = 1'b1;
    #1;
    n_cmp++;
    if (dec_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_busy_cleared: got %b required 1", dec_ready); end
    tick();
    dec_valid = 1'b0;
    tick();
    while (exp_q.size() != 0 || act_q.size() != 0) begin
      n_cmp++;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : bnd_t'('x);
      a = (act_q.size() != 0) ? act_q.pop_front() : bnd_t'('x);
      if (a !== e) begin n_err++; $display("FAIL rstmid_bundle: got %h required %h", a, e); end
    end
  endtask

  initial begin
    rst = 1'b1; ex_ready = 1'b0;
    dec_valid = 1'b0; dec_rs1 = '0; dec_rs2 = '0; dec_rd = '0; dec_wen = 1'b0;
    wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
    test_reset();
    test_rf_write();
    test_basic();
    test_hazard();
    test_hold();
    test_zero();
    test_same_cycle();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
